// File: rtl/cfg_arb_pkg.sv
// Shared types for the two-requester APB configuration arbiter.
package cfg_arb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int CMD_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } cfg_arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } cfg_arb_cmd_t;

endpackage

// File: rtl/cfg_apb_arbiter.sv
// Round-robin share of one APB config port between host path and sequencer,
// one transfer in flight, with bus-hang timeout and error reply.
module cfg_apb_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_write,
  input  logic [1:0][ADDR_W-1:0]     req_addr,
  input  logic [1:0][APB_DATA_W-1:0] req_wdata,
  output logic [1:0]                 rsp_valid,
  output logic [APB_DATA_W-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDR_W-1:0]          apb_paddr,
  output logic                       apb_psel,
  output logic                       apb_penable,
  output logic                       apb_pwrite,
  output logic [APB_DATA_W-1:0]      apb_pwdata,
  output logic [3:0]                 apb_pwstrb,
  input  logic [APB_DATA_W-1:0]      apb_prdata,
  input  logic                       apb_pready,
  input  logic                       apb_pslverr,
  output logic [15:0]                timeout_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  cfg_arb_state_e        r_state;
  cfg_arb_state_e        w_next;
  cfg_arb_cmd_t          r_cmd;
  logic                  r_gnt;
  logic                  r_last;
  logic [CNT_W-1:0]      r_tcnt;
  logic [APB_DATA_W-1:0] r_rdata;
  logic                  r_err;
  logic [15:0]           r_tocnt;

  logic w_any;
  logic w_gnt;
  logic w_done;
  logic w_tout;

  assign w_any  = |req_valid;
  // Tie goes to whoever did not win last; a lone requester always wins.
  assign w_gnt  = (&req_valid) ? ~r_last : req_valid[1];
  assign w_done = (r_state == ACCESS) && apb_pready;
  assign w_tout = (r_state == ACCESS) && !apb_pready
                  && (r_tcnt == TO_LAST);

  assign rsp_rdata     = r_rdata;
  assign rsp_err       = r_err;
  assign timeout_count = r_tocnt;

  always_comb begin
    w_next      = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    apb_paddr   = '0;
    apb_pwrite  = 1'b0;
    apb_pwdata  = '0;
    apb_pwstrb  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any && rstn) begin
          req_ready[w_gnt] = 1'b1;
          w_next           = SETUP;
        end
      end
      SETUP, ACCESS: begin
        apb_psel    = 1'b1;
        apb_penable = (r_state == ACCESS);
        apb_paddr   = ADDR_W'(r_cmd.addr);
        apb_pwrite  = r_cmd.write;
        apb_pwdata  = r_cmd.wdata;
        apb_pwstrb  = r_cmd.write ? 4'hF : 4'h0;
        if (r_state == SETUP) begin
          w_next = ACCESS;
        end else if (w_done || w_tout) begin
          w_next = RESP;
        end
      end
      RESP: begin
        rsp_valid[r_gnt] = 1'b1;
        w_next           = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_tcnt  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_tocnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_cmd.write <= req_write[w_gnt];
        r_cmd.addr  <= CMD_ADDR_W'(req_addr[w_gnt]);
        r_cmd.wdata <= req_wdata[w_gnt];
        r_gnt       <= w_gnt;
        r_last      <= w_gnt;
        r_tcnt      <= '0;
      end
      if (r_state == ACCESS) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_done) begin
        r_rdata <= r_cmd.write ? '0 : apb_prdata;
        r_err   <= apb_pslverr;
      end else if (w_tout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
        if (r_tocnt != 16'hFFFF) begin
          r_tocnt <= r_tocnt + 16'd1;
        end
      end
    end
  end

endmodule
